sample_mixer: RTL and testbench
===============================

SAMPLE_MIXER -- requirements
Module: sample_mixer

Interface
REQ-001 Parameter DATA_W, default 16: signed sample and RAM data width.
REQ-002 Parameter NUM_BANKS, default 8: number of loop banks, one bit each in playing and recording.
REQ-003 Port clk_100MHz, input, 1: the only clock; one clock; reset is asynchronous and active-low.
REQ-004 Port rstn, input, 1: asynchronous active-low reset.
REQ-005 Port playing, input, NUM_BANKS: per-bank play enable.
REQ-006 Port recording, input, NUM_BANKS: per-bank record enable.
REQ-007 Port mem_bank, input, 3: bank index of the current memory access.
REQ-008 Port get_data, input, 1: one-cycle pulse that starts a bank write.
REQ-009 Port data_ready, input, 1: one-cycle pulse that ends a bank access.
REQ-010 Port mix_data, input, 1: one-cycle pulse, once per 44.1 kHz frame, after the last bank.
REQ-011 Port write_zero, input, 1: erase mode is active.
REQ-012 Port sample_in, input, DATA_W: live signed input sample.
REQ-013 Port ram_dq_i, input, DATA_W: RAM read data.
REQ-014 Port ram_dq_o, output, DATA_W: RAM write data.
REQ-015 Port ram_dq_oe, output, 1: RAM data-bus drive enable.
REQ-016 Port mix_out, output, DATA_W: signed saturated mix.
REQ-017 Port mix_valid, output, 1: one-cycle strobe when mix_out updates.

Function
REQ-018 State machine states: IDLE, DRIVE, SUM, OUT.
REQ-019 In IDLE, get_data while recording[mem_bank]=1 shall latch sample_in into ram_dq_o, set ram_dq_oe=1 on the next cycle, and enter DRIVE.
REQ-020 In DRIVE, data_ready shall clear ram_dq_oe on the next cycle and return to IDLE; ram_dq_o shall hold stable throughout DRIVE.
REQ-021 While write_zero=1: ram_dq_o=0 and ram_dq_oe=1 combinationally, regardless of state; get_data is ignored.
REQ-022 On every data_ready, bank_reg[mem_bank] shall load ram_dq_i if playing[mem_bank]=1 and recording[mem_bank]=0, and load 0 otherwise.
REQ-023 mix_data in IDLE shall snapshot all bank_regs into shadow registers, initialise the accumulator (width DATA_W+4, sign-extended), and enter SUM.
REQ-024 SUM shall add one shadow register per cycle, bank 0 through 7, over exactly 8 cycles, then enter OUT.
REQ-025 OUT shall load mix_out with the accumulator saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], pulse mix_valid for one cycle, and return to IDLE.
REQ-026 Latency: mix_data at cycle T produces mix_valid at T+10.
REQ-027 mix_data outside IDLE shall be ignored.
REQ-028 data_ready during SUM or OUT shall still update bank_reg and shall not affect the mix in progress.
REQ-029 get_data outside IDLE shall be ignored.
REQ-030 If get_data and data_ready arrive in the same cycle, get_data takes priority and DRIVE is entered.
REQ-031 mem_bank index arithmetic shall not wrap; mem_bank values of NUM_BANKS or more shall be ignored for capture.

Reset
REQ-032 rstn=0 shall asynchronously force state IDLE and clear mix_out, mix_valid, ram_dq_o, ram_dq_oe, bank_regs, shadow registers, and the accumulator; this holds mid-DRIVE and mid-SUM.
REQ-033 The first mix_data after reset release shall be accepted normally.

Configuration
REQ-034 Macro SAMPLE_MIXER_MONITOR_EN.
- Defined: the accumulator initialises to sign-extended sample_in at mix_data (live monitoring).
- Undefined: the accumulator initialises to 0.
- Latency is identical in both builds.

Structure
REQ-035 Shared package sample_mixer_pkg shall hold DATA_W, NUM_BANKS, ACC_W=DATA_W+4, SUM_CYCLES=8, and the state encoding constants.
REQ-036 Saturation shall be implemented in one sub-module, sample_sat (ACC_W in, DATA_W out, combinational); all other logic shall stay in sample_mixer.

Verification
REQ-037 Reset/outputs: assert rstn=0 mid-SUM -> state IDLE, all outputs 0 immediately; no mix_valid appears after release.
REQ-038 Record: recording=8'h04, mem_bank=2, sample_in=16'h1234, get_data pulse -> ram_dq_oe=1 and ram_dq_o=16'h1234 until data_ready, then ram_dq_oe=0 the next cycle.
REQ-039 Mix: playing=8'h03, data_ready captures 16'h1000 (bank 0) and 16'h0200 (bank 1), mix_data at T -> mix_out=16'h1200 with mix_valid at T+10, monitor undefined.
REQ-040 Saturation: all 8 banks read 16'h7000 -> mix_out=16'h7FFF; all 8 read 16'h9000 -> mix_out=16'h8000.
REQ-041 Erase: write_zero=1 with a get_data pulse -> ram_dq_o=0, ram_dq_oe=1 continuously, state stays IDLE.
REQ-042 Monitor build: SAMPLE_MIXER_MONITOR_EN defined, no banks playing, sample_in=16'hFFF0 -> mix_out=16'hFFF0.

Source files
------------

// File: rtl/sample_mixer_pkg.sv
// sample_mixer_pkg: shared widths, sizes and state encoding for the loop-bank mixer
// Contents: DATA_W, NUM_BANKS, ACC_W, SUM_CYCLES, state_t
package sample_mixer_pkg;
    localparam int DATA_W     = 16;
    localparam int NUM_BANKS  = 8;
    localparam int ACC_W      = DATA_W + 4;
    localparam int SUM_CYCLES = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        SUM   = 2'd2,
        OUT   = 2'd3
    } state_t;
endpackage

// File: rtl/sample_mixer_sat.sv
// sample_sat: clamps a signed accumulator into the signed output sample range
// Ports:
//   acc_in  [IN_W]  signed accumulator value
//   sat_out [OUT_W] value clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sample_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  acc_in,
    output logic [OUT_W-1:0] sat_out
);
    logic [IN_W-OUT_W:0] hi;
    logic                ovf;
    // The value fits only when every bit from the output sign bit upward agrees.
    always_comb begin
        hi      = acc_in[IN_W-1:OUT_W-1];
        ovf     = !((&hi) || !(|hi));
        sat_out = !ovf ? acc_in[OUT_W-1:0] :
                  acc_in[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
endmodule

// File: rtl/sample_mixer.sv
// sample_mixer: loop-bank record sequencer and saturating per-frame mixer
// Ports:
//   clk_100MHz, rstn          clock, asynchronous active-low reset
//   playing, recording        per-bank play / record enables
//   mem_bank                  bank index of the current memory access
//   get_data, data_ready      start / end of a bank access (one-cycle pulses)
//   mix_data                  once-per-frame pulse that starts a mix
//   write_zero                erase mode: forces zero onto the RAM bus
//   sample_in, ram_dq_i       live input sample, RAM read data
//   ram_dq_o, ram_dq_oe       RAM write data and bus drive enable
//   mix_out, mix_valid        saturated mix and its one-cycle update strobe
// Build option: define SAMPLE_MIXER_MONITOR_EN to seed each mix with the live sample_in.
module sample_mixer
    import sample_mixer_pkg::*;
#(
    parameter int DATA_W    = sample_mixer_pkg::DATA_W,
    parameter int NUM_BANKS = sample_mixer_pkg::NUM_BANKS
) (
    input  logic                 clk_100MHz,
    input  logic                 rstn,
    input  logic [NUM_BANKS-1:0] playing,
    input  logic [NUM_BANKS-1:0] recording,
    input  logic [2:0]           mem_bank,
    input  logic                 get_data,
    input  logic                 data_ready,
    input  logic                 mix_data,
    input  logic                 write_zero,
    input  logic [DATA_W-1:0]    sample_in,
    input  logic [DATA_W-1:0]    ram_dq_i,
    output logic [DATA_W-1:0]    ram_dq_o,
    output logic                 ram_dq_oe,
    output logic [DATA_W-1:0]    mix_out,
    output logic                 mix_valid
);
    localparam int AW = DATA_W + 4;
    localparam int CW = $clog2(SUM_CYCLES);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     acc;
    logic [DATA_W-1:0] dq_q;
    logic              oe_q;
    logic [DATA_W-1:0] bank_reg [NUM_BANKS];
    logic [DATA_W-1:0] shadow   [NUM_BANKS];
    logic              bank_ok;
    logic              bank_live;
    logic              rec_go;
    logic [AW-1:0]     acc_init;
    logic [AW-1:0]     sum_term;
    logic [DATA_W-1:0] sat_val;

    // Out-of-range bank indices are dropped rather than wrapped onto a real bank.
    always_comb begin
        bank_ok   = int'(mem_bank) < NUM_BANKS;
        bank_live = bank_ok && playing[mem_bank] && !recording[mem_bank];
        rec_go    = get_data && !write_zero && bank_ok && recording[mem_bank];
`ifdef SAMPLE_MIXER_MONITOR_EN
        acc_init  = {{(AW-DATA_W){sample_in[DATA_W-1]}}, sample_in};
`else
        acc_init  = '0;
`endif
        sum_term  = {{(AW-DATA_W){shadow[cnt][DATA_W-1]}}, shadow[cnt]};
        ram_dq_o  = write_zero ? '0 : dq_q;
        ram_dq_oe = write_zero || oe_q;
    end

    sample_sat #(.IN_W(AW), .OUT_W(DATA_W)) u_sat (
        .acc_in  (acc),
        .sat_out (sat_val)
    );

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            dq_q      <= '0;
            oe_q      <= 1'b0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_reg[i] <= '0;
                shadow[i]   <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            // Bank capture runs in every state; the mix works from the shadow copy.
            if (data_ready && bank_ok)
                bank_reg[mem_bank] <= bank_live ? ram_dq_i : '0;
            case (state)
                IDLE: begin
                    if (rec_go) begin
                        dq_q  <= sample_in;
                        oe_q  <= 1'b1;
                        state <= DRIVE;
                    end else if (mix_data) begin
                        shadow <= bank_reg;
                        acc    <= acc_init;
                        cnt    <= '0;
                        state  <= SUM;
                    end
                end
                DRIVE: begin
                    if (data_ready) begin
                        oe_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SUM: begin
                    acc   <= acc + sum_term;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(SUM_CYCLES - 1)) ? OUT : SUM;
                end
                OUT: begin
                    mix_out   <= sat_val;
                    mix_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_mixer.sv
// tb_sample_mixer: vector table plus directed sequences for the loop-bank mixer
module tb_sample_mixer;
    import sample_mixer_pkg::*;

    logic        clk_100MHz = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  playing = '0;
    logic [7:0]  recording = '0;
    logic [2:0]  mem_bank = '0;
    logic        get_data = 1'b0;
    logic        data_ready = 1'b0;
    logic        mix_data = 1'b0;
    logic        write_zero = 1'b0;
    logic [15:0] sample_in = '0;
    logic [15:0] ram_dq_i = '0;
    logic [15:0] ram_dq_o;
    logic        ram_dq_oe;
    logic [15:0] mix_out;
    logic        mix_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb_q [$];

    typedef struct {
        logic [7:0]       play;
        logic [7:0]       rec;
        logic [7:0][15:0] v;
        logic [15:0]      exp;
        string            name;
    } vec_t;
    vec_t vecs [9];

    sample_mixer dut (
        .clk_100MHz (clk_100MHz),
        .rstn       (rstn),
        .playing    (playing),
        .recording  (recording),
        .mem_bank   (mem_bank),
        .get_data   (get_data),
        .data_ready (data_ready),
        .mix_data   (mix_data),
        .write_zero (write_zero),
        .sample_in  (sample_in),
        .ram_dq_i   (ram_dq_i),
        .ram_dq_o   (ram_dq_o),
        .ram_dq_oe  (ram_dq_oe),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_ready(input logic [2:0] b, input logic [15:0] val);
        mem_bank   = b;
        ram_dq_i   = val;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic load_banks(input logic [7:0] play, input logic [7:0] rec, input logic [7:0][15:0] v);
        playing   = play;
        recording = rec;
        for (int b = 0; b < 8; b++) pulse_ready(3'(b), v[b]);
        recording = '0;
    endtask

    // Starts a mix and waits for its strobe; optionally disturbs the mix while it runs.
    task automatic run_mix(input string name, input logic [15:0] exp, input bit inject);
        int lat = 0;
        int extra = 0;
        logic [15:0] e;
        sb_q.push_back(exp);
        mix_data = 1'b1;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            mix_data = 1'b0;
            data_ready = 1'b0;
            if (inject && n == 3) begin
                mem_bank   = 3'd0;
                ram_dq_i   = 16'h7000;
                data_ready = 1'b1;
                mix_data   = 1'b1;
            end
            if (mix_valid) lat = n;
        end
        mix_data   = 1'b0;
        data_ready = 1'b0;
        if (lat == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no mix_valid within 20 cycles", name);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check({name, "_out"}, 32'(mix_out), 32'(e));
            check({name, "_lat"}, 32'(lat), 32'd10);
            tick();
            check({name, "_pulse"}, 32'(mix_valid), 32'd0);
            for (int n = 0; n < 12; n++) begin
                if (mix_valid) extra++;
                tick();
            end
            check({name, "_extra"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int seen;
        vecs[0] = '{8'h03, 8'h00, {{6{16'h1111}}, 16'h0200, 16'h1000}, 16'h1200, "two_banks"};
        vecs[1] = '{8'hFF, 8'h00, {8{16'h7000}}, 16'h7FFF, "sat_pos"};
        vecs[2] = '{8'hFF, 8'h00, {8{16'h9000}}, 16'h8000, "sat_neg"};
        vecs[3] = '{8'hFF, 8'h00, {8{16'h0FFF}}, 16'h7FF8, "near_max"};
        vecs[4] = '{8'hFF, 8'h00, {8{16'h1000}}, 16'h7FFF, "max_plus1"};
        vecs[5] = '{8'hFF, 8'h00, {8{16'hF000}}, 16'h8000, "exact_min"};
        vecs[6] = '{8'h80, 8'h00, {16'hFFFF, {7{16'h0000}}}, 16'hFFFF, "bank7_neg"};
        vecs[7] = '{8'hAA, 8'h00, {4{16'h0100, 16'h7000}}, 16'h0400, "odd_banks"};
        vecs[8] = '{8'hFF, 8'h01, {{7{16'h0001}}, 16'h4000}, 16'h0007, "rec_masks"};

        #12;
        check("rst_mix_out", 32'(mix_out), 32'd0);
        check("rst_mix_valid", 32'(mix_valid), 32'd0);
        check("rst_dq_o", 32'(ram_dq_o), 32'd0);
        check("rst_dq_oe", 32'(ram_dq_oe), 32'd0);
        rstn = 1'b1;
        tick();

        // Recording handshake
        recording = 8'h04;
        mem_bank  = 3'd2;
        sample_in = 16'h1234;
        get_data  = 1'b1;
        tick();
        get_data = 1'b0;
        check("rec_oe", 32'(ram_dq_oe), 32'd1);
        check("rec_dq", 32'(ram_dq_o), 32'h1234);
        sample_in = 16'h5555;
        mix_data  = 1'b1;
        tick();
        mix_data = 1'b0;
        tick();
        check("rec_hold_dq", 32'(ram_dq_o), 32'h1234);
        check("rec_hold_oe", 32'(ram_dq_oe), 32'd1);
        check("rec_mix_ignored", 32'(dut.state), 32'(DRIVE));
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("rec_end_oe", 32'(ram_dq_oe), 32'd0);
        check("rec_end_state", 32'(dut.state), 32'(IDLE));
        get_data   = 1'b1;
        data_ready = 1'b1;
        tick();
        get_data   = 1'b0;
        data_ready = 1'b0;
        check("gd_dr_prio_oe", 32'(ram_dq_oe), 32'd1);
        check("gd_dr_prio_dq", 32'(ram_dq_o), 32'h5555);
        pulse_ready(3'd2, 16'h0);
        check("gd_dr_end_oe", 32'(ram_dq_oe), 32'd0);
        mem_bank = 3'd3;
        get_data = 1'b1;
        tick();
        get_data = 1'b0;
        check("rec_off_bank", 32'(ram_dq_oe), 32'd0);

        // Erase mode
        write_zero = 1'b1;
        #1;
        check("erase_comb_dq", 32'(ram_dq_o), 32'd0);
        check("erase_comb_oe", 32'(ram_dq_oe), 32'd1);
        mem_bank  = 3'd2;
        sample_in = 16'hBEEF;
        get_data  = 1'b1;
        tick();
        get_data = 1'b0;
        tick();
        check("erase_state", 32'(dut.state), 32'(IDLE));
        check("erase_dq", 32'(ram_dq_o), 32'd0);
        check("erase_oe", 32'(ram_dq_oe), 32'd1);
        write_zero = 1'b0;
        recording  = '0;
        sample_in  = '0;
        #1;
        check("erase_off_oe", 32'(ram_dq_oe), 32'd0);

        // Mix vectors
        foreach (vecs[i]) begin
            load_banks(vecs[i].play, vecs[i].rec, vecs[i].v);
            run_mix(vecs[i].name, vecs[i].exp, 1'b0);
        end

        // Capture during SUM updates the bank but not the mix in flight
        load_banks(8'hFF, 8'h00, {8{16'h0100}});
        run_mix("sum_capture", 16'h0800, 1'b1);
        run_mix("after_capture", 16'h7700, 1'b0);

`ifdef SAMPLE_MIXER_MONITOR_EN
        load_banks(8'h00, 8'h00, {8{16'h1234}});
        sample_in = 16'hFFF0;
        run_mix("monitor", 16'hFFF0, 1'b0);
        sample_in = '0;
`else
        load_banks(8'h00, 8'h00, {8{16'h1234}});
        sample_in = 16'hFFF0;
        run_mix("no_monitor", 16'h0000, 1'b0);
        sample_in = '0;
`endif

        // Reset in the middle of SUM
        load_banks(8'hFF, 8'h00, {8{16'h0100}});
        mix_data = 1'b1;
        tick();
        mix_data = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_state", 32'(dut.state), 32'(SUM));
        rstn = 1'b0;
        #1;
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_mix_out", 32'(mix_out), 32'd0);
        check("mid_rst_valid", 32'(mix_valid), 32'd0);
        check("mid_rst_dq", 32'(ram_dq_o), 32'd0);
        check("mid_rst_oe", 32'(ram_dq_oe), 32'd0);
        check("mid_rst_acc", 32'(dut.acc), 32'd0);
        tick();
        rstn = 1'b1;
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (mix_valid) seen++;
        end
        check("post_rst_no_valid", 32'(seen), 32'd0);
        run_mix("first_after_rst", 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
